multicycle_control: RTL and testbench

//  Moore/Mealy FSM that sequences the shared multicycle MIPS datapath:
//  one memory, one ALU, IR, PC and register file.

---
 rtl/multicycle_control_if.sv | 31 +++
 rtl/multicycle_control.sv | 227 ++++++++++++++++++++++
 tb/tb_multicycle_control.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_control_if.sv
// Control bus between the multicycle MIPS controller and its datapath.
// master = controller side, slave = datapath side.
interface multicycle_control_if;
   logic [5:0] Opcode;
   logic       MemReady;
   logic       PCWrite;
   logic       IorD;
   logic       MemRead;
   logic       MemWrite;
   logic       IRWrite;
   logic       RegDst;
   logic       MemtoReg;
   logic       RegWrite;
   logic       ALUSrcA;
   logic [1:0] ALUSrcB;
   logic [1:0] ALUOp;
   logic       Branch;
   logic [1:0] PCSrc;

   modport master (
      input  Opcode, MemReady,
      output PCWrite, IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg,
             RegWrite, ALUSrcA, ALUSrcB, ALUOp, Branch, PCSrc
   );

   modport slave (
      output Opcode, MemReady,
      input  PCWrite, IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg,
             RegWrite, ALUSrcA, ALUSrcB, ALUOp, Branch, PCSrc
   );
endinterface

// File: rtl/multicycle_control.sv
// Multicycle MIPS control FSM with memory-ready stall, wait timeout and retire counter.
// Define MCU_JUMP_EN to decode opcode 000010 as a jump; otherwise it halts as illegal.
//
// state  | meaning
// IDLE   | after reset, all outputs 0
// FETCH  | read instruction at PC, PC+4; waits on MemReady
// DECODE | branch target precompute, opcode dispatch
// MEMADR | effective address rs+imm
// MEMRD  | load data read; waits on MemReady
// MEMWB  | load writeback to rt, retire
// MEMWR  | store write; waits on MemReady, retire
// REX    | R-type ALU op
// RWB    | R-type writeback to rd, retire
// BEQ    | compare and conditional PC load, retire
// JUMP   | PC load from jump target, retire
// HALT   | illegal opcode or memory timeout; exits on reset only
module multicycle_control #(
   parameter int CNT_W   = 32,
   parameter int TIMEOUT = 16
) (
   input  logic                     clk,
   input  logic                     reset,
   multicycle_control_if.master     bus,
   output logic                     InstrDone,
   output logic [CNT_W-1:0]         RetiredCnt,
   output logic                     Halted,
   output logic [3:0]               State
);

   localparam int WAIT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
`ifdef MCU_JUMP_EN
   localparam logic [5:0] OP_J     = 6'b000010;
`endif

   typedef enum logic [3:0] {
      S_IDLE   = 4'd0,
      S_FETCH  = 4'd1,
      S_DECODE = 4'd2,
      S_MEMADR = 4'd3,
      S_MEMRD  = 4'd4,
      S_MEMWB  = 4'd5,
      S_MEMWR  = 4'd6,
      S_REX    = 4'd7,
      S_RWB    = 4'd8,
      S_BEQ    = 4'd9,
      S_JUMP   = 4'd10,
      S_HALT   = 4'd11
   } state_t;

   typedef struct packed {
      logic       fetch;
      logic       pc_write;
      logic       iord;
      logic       mem_read;
      logic       mem_write;
      logic       reg_dst;
      logic       mem_to_reg;
      logic       reg_write;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] alu_op;
      logic       branch;
      logic [1:0] pc_src;
      logic       halted;
   } ctl_t;

   state_t              state_q, state_d;
   ctl_t                ctl_q, ctl_d;
   logic [WAIT_W-1:0]   wait_q, wait_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                retire;
   logic                mem_state;

   // Moore outputs are decoded from the next state so they sit in flops
   // aligned with state_q; only MemReady-qualified terms stay combinational.
   function automatic ctl_t decode(input state_t s);
      ctl_t c;
      c = '0;
      case (s)
         S_FETCH: begin
            c.fetch     = 1'b1;
            c.mem_read  = 1'b1;
            c.alu_src_b = 2'b01;
         end
         S_DECODE: c.alu_src_b = 2'b11;
         S_MEMADR: begin
            c.alu_src_a = 1'b1;
            c.alu_src_b = 2'b10;
         end
         S_MEMRD: begin
            c.iord     = 1'b1;
            c.mem_read = 1'b1;
         end
         S_MEMWB: begin
            c.mem_to_reg = 1'b1;
            c.reg_write  = 1'b1;
         end
         S_MEMWR: begin
            c.iord      = 1'b1;
            c.mem_write = 1'b1;
         end
         S_REX: begin
            c.alu_src_a = 1'b1;
            c.alu_op    = 2'b10;
         end
         S_RWB: begin
            c.reg_dst   = 1'b1;
            c.reg_write = 1'b1;
         end
         S_BEQ: begin
            c.alu_src_a = 1'b1;
            c.alu_op    = 2'b01;
            c.branch    = 1'b1;
            c.pc_src    = 2'b01;
         end
         S_JUMP: begin
            c.pc_write = 1'b1;
            c.pc_src   = 2'b10;
         end
         S_HALT:  c.halted = 1'b1;
         default: c = '0;
      endcase
      return c;
   endfunction

   always_comb begin
      state_d   = state_q;
      wait_d    = '0;
      cnt_d     = cnt_q;
      retire    = 1'b0;
      mem_state = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);

      case (state_q)
         S_IDLE:   state_d = S_FETCH;
         S_FETCH:  if (bus.MemReady) state_d = S_DECODE;
         S_DECODE: begin
            case (bus.Opcode)
               OP_RTYPE:     state_d = S_REX;
               OP_LW, OP_SW: state_d = S_MEMADR;
               OP_BEQ:       state_d = S_BEQ;
`ifdef MCU_JUMP_EN
               OP_J:         state_d = S_JUMP;
`endif
               default:      state_d = S_HALT;
            endcase
         end
         S_MEMADR: begin
            case (bus.Opcode)
               OP_LW:   state_d = S_MEMRD;
               OP_SW:   state_d = S_MEMWR;
               default: state_d = S_HALT;
            endcase
         end
         S_MEMRD:  if (bus.MemReady) state_d = S_MEMWB;
         S_MEMWB: begin
            state_d = S_FETCH;
            retire  = 1'b1;
         end
         S_MEMWR: begin
            if (bus.MemReady) begin
               state_d = S_FETCH;
               retire  = 1'b1;
            end
         end
         S_REX:    state_d = S_RWB;
         S_RWB, S_BEQ, S_JUMP: begin
            state_d = S_FETCH;
            retire  = 1'b1;
         end
         S_HALT:   state_d = S_HALT;
         default:  state_d = S_HALT;
      endcase

      // Counter is zero on entry to every memory state because it only
      // survives a cycle that stays in place with MemReady low.
      if (mem_state && !bus.MemReady) begin
         if (wait_q == WAIT_W'(TIMEOUT - 1)) begin
            state_d = S_HALT;
         end else begin
            wait_d = wait_q + 1'b1;
         end
      end

      if (retire) cnt_d = cnt_q + 1'b1;

      ctl_d = decode(state_d);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         ctl_q   <= '0;
         wait_q  <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         ctl_q   <= ctl_d;
         wait_q  <= wait_d;
         cnt_q   <= cnt_d;
      end
   end

   assign bus.PCWrite  = ctl_q.pc_write | (ctl_q.fetch & bus.MemReady);
   assign bus.IRWrite  = ctl_q.fetch & bus.MemReady;
   assign bus.IorD     = ctl_q.iord;
   assign bus.MemRead  = ctl_q.mem_read;
   assign bus.MemWrite = ctl_q.mem_write;
   assign bus.RegDst   = ctl_q.reg_dst;
   assign bus.MemtoReg = ctl_q.mem_to_reg;
   assign bus.RegWrite = ctl_q.reg_write;
   assign bus.ALUSrcA  = ctl_q.alu_src_a;
   assign bus.ALUSrcB  = ctl_q.alu_src_b;
   assign bus.ALUOp    = ctl_q.alu_op;
   assign bus.Branch   = ctl_q.branch;
   assign bus.PCSrc    = ctl_q.pc_src;

   assign InstrDone  = retire;
   assign RetiredCnt = cnt_q;
   assign Halted     = ctl_q.halted;
   assign State      = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: directed table, hand sequences and random
// instruction streams checked against an instruction-level expected trace.
module tb_multicycle_control;

   localparam int CNT_W   = 4;
   localparam int TIMEOUT = 16;

   localparam logic [5:0] OP_R   = 6'h00;
   localparam logic [5:0] OP_LW  = 6'h23;
   localparam logic [5:0] OP_SW  = 6'h2B;
   localparam logic [5:0] OP_BEQ = 6'h04;
   localparam logic [5:0] OP_J   = 6'h02;

   // {PCWrite,IorD,MemRead,MemWrite,IRWrite,RegDst,MemtoReg,RegWrite,ALUSrcA,ALUSrcB,ALUOp,Branch,PCSrc,Halted}
   function automatic logic [16:0] mk(input logic pcw, input logic iord, input logic mr,
                                      input logic mw, input logic irw, input logic rd,
                                      input logic m2r, input logic rw, input logic sa,
                                      input logic [1:0] sb, input logic [1:0] aop,
                                      input logic br, input logic [1:0] ps, input logic h);
      return {pcw, iord, mr, mw, irw, rd, m2r, rw, sa, sb, aop, br, ps, h};
   endfunction

   localparam logic [16:0] C_IDLE      = 17'd0;
   localparam logic [16:0] C_FETCH     = mk(0,0,1,0,0,0,0,0,0,2'b01,2'b00,0,2'b00,0);
   localparam logic [16:0] C_FETCH_RDY = mk(1,0,1,0,1,0,0,0,0,2'b01,2'b00,0,2'b00,0);
   localparam logic [16:0] C_DECODE    = mk(0,0,0,0,0,0,0,0,0,2'b11,2'b00,0,2'b00,0);
   localparam logic [16:0] C_MEMADR    = mk(0,0,0,0,0,0,0,0,1,2'b10,2'b00,0,2'b00,0);
   localparam logic [16:0] C_MEMRD     = mk(0,1,1,0,0,0,0,0,0,2'b00,2'b00,0,2'b00,0);
   localparam logic [16:0] C_MEMWB     = mk(0,0,0,0,0,0,1,1,0,2'b00,2'b00,0,2'b00,0);
   localparam logic [16:0] C_MEMWR     = mk(0,1,0,1,0,0,0,0,0,2'b00,2'b00,0,2'b00,0);
   localparam logic [16:0] C_REX       = mk(0,0,0,0,0,0,0,0,1,2'b00,2'b10,0,2'b00,0);
   localparam logic [16:0] C_RWB       = mk(0,0,0,0,0,1,0,1,0,2'b00,2'b00,0,2'b00,0);
   localparam logic [16:0] C_BEQ       = mk(0,0,0,0,0,0,0,0,1,2'b00,2'b01,1,2'b01,0);
   localparam logic [16:0] C_JUMP      = mk(1,0,0,0,0,0,0,0,0,2'b00,2'b00,0,2'b10,0);
   localparam logic [16:0] C_HALT      = mk(0,0,0,0,0,0,0,0,0,2'b00,2'b00,0,2'b00,1);

   typedef struct {
      logic [5:0]  op;
      logic        rdy;
      logic [3:0]  st;
      logic [16:0] ctl;
      logic        done;
      int          cnt;
   } vec_t;

   logic             clk;
   logic             reset;
   logic             InstrDone;
   logic [CNT_W-1:0] RetiredCnt;
   logic             Halted;
   logic [3:0]       State;

   multicycle_control_if bus();

   multicycle_control #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
      .clk        (clk),
      .reset      (reset),
      .bus        (bus),
      .InstrDone  (InstrDone),
      .RetiredCnt (RetiredCnt),
      .Halted     (Halted),
      .State      (State)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int   total;
   int   bad;
   int   mcnt;
   vec_t q[$];
   vec_t tab[16];

   function automatic logic [16:0] act_ctl();
      return {bus.PCWrite, bus.IorD, bus.MemRead, bus.MemWrite, bus.IRWrite, bus.RegDst,
              bus.MemtoReg, bus.RegWrite, bus.ALUSrcA, bus.ALUSrcB, bus.ALUOp,
              bus.Branch, bus.PCSrc, Halted};
   endfunction

   function automatic logic [5:0] r6();
      return 6'($urandom);
   endfunction

   function automatic logic r1();
      return 1'($urandom);
   endfunction

   task automatic check(input string nm, input logic [3:0] st, input logic [16:0] ctl,
                        input logic done, input int cnt);
      logic [CNT_W-1:0] ecnt;
      ecnt  = cnt[CNT_W-1:0];
      total = total + 1;
      if (State !== st || act_ctl() !== ctl || InstrDone !== done || RetiredCnt !== ecnt) begin
         bad = bad + 1;
         $display("FAIL %s: got st=%0d ctl=%h done=%b cnt=%0d, want st=%0d ctl=%h done=%b cnt=%0d",
                  nm, State, act_ctl(), InstrDone, RetiredCnt, st, ctl, done, ecnt);
      end
   endtask

   task automatic run_vec(input vec_t v, input string nm);
      @(negedge clk);
      bus.Opcode   = v.op;
      bus.MemReady = v.rdy;
      #2;
      check(nm, v.st, v.ctl, v.done, v.cnt);
   endtask

   task automatic run_q(input string nm);
      vec_t v;
      int   i;
      i = 0;
      while (q.size() > 0) begin
         v = q.pop_front();
         run_vec(v, $sformatf("%s[%0d]", nm, i));
         i++;
      end
   endtask

   // Reset asserted mid-cycle must clear everything before any clock edge.
   task automatic do_reset(input string nm);
      @(negedge clk);
      #2 reset = 1'b1;
      #1 check({nm, "_async"}, 4'd0, C_IDLE, 1'b0, 0);
      @(negedge clk);
      reset        = 1'b0;
      bus.Opcode   = r6();
      bus.MemReady = r1();
      mcnt         = 0;
      #2 check({nm, "_idle"}, 4'd0, C_IDLE, 1'b0, 0);
   endtask

   task automatic push(input logic [5:0] op, input logic rdy, input logic [3:0] st,
                       input logic [16:0] ctl, input logic done);
      vec_t v;
      v.op   = op;
      v.rdy  = rdy;
      v.st   = st;
      v.ctl  = ctl;
      v.done = done;
      v.cnt  = mcnt;
      q.push_back(v);
      if (done) mcnt++;
   endtask

   task automatic gen_mem(input logic [3:0] st, input logic [16:0] ctl, input int w,
                          input logic done_last);
      for (int i = 0; i < w; i++) push(r6(), 1'b0, st, ctl, 1'b0);
      push(r6(), 1'b1, st, ctl, done_last);
   endtask

   // Expected per-cycle trace of one legal instruction, given its wait counts.
   task automatic gen_instr(input logic [5:0] op, input int wf, input int wm);
      gen_mem(4'd1, C_FETCH, wf, 1'b0);
      q[q.size()-1].ctl = C_FETCH_RDY;
      push(op, r1(), 4'd2, C_DECODE, 1'b0);
      case (op)
         OP_R: begin
            push(r6(), r1(), 4'd7, C_REX, 1'b0);
            push(r6(), r1(), 4'd8, C_RWB, 1'b1);
         end
         OP_LW: begin
            push(op, r1(), 4'd3, C_MEMADR, 1'b0);
            gen_mem(4'd4, C_MEMRD, wm, 1'b0);
            push(r6(), r1(), 4'd5, C_MEMWB, 1'b1);
         end
         OP_SW: begin
            push(op, r1(), 4'd3, C_MEMADR, 1'b0);
            gen_mem(4'd6, C_MEMWR, wm, 1'b1);
         end
         OP_BEQ:  push(r6(), r1(), 4'd9, C_BEQ, 1'b1);
         default: push(r6(), r1(), 4'd10, C_JUMP, 1'b1);
      endcase
   endtask

   function automatic int pick_wait();
      int r;
      r = $urandom_range(0, 5);
      if (r < 3) return 0;
      if (r == 3) return 1;
      if (r == 4) return 2;
      return TIMEOUT - 1;
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish, want finish before time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [5:0] ops[5];
      int         nops;
      total        = 0;
      bad          = 0;
      mcnt         = 0;
      reset        = 1'b0;
      bus.Opcode   = 6'h00;
      bus.MemReady = 1'b0;

      // R-type, LW with two wait cycles in MEMRD, then BEQ
      tab[0]  = '{6'h3F, 1'b1, 4'd1, C_FETCH_RDY, 1'b0, 0};
      tab[1]  = '{OP_R,  1'b0, 4'd2, C_DECODE,    1'b0, 0};
      tab[2]  = '{OP_LW, 1'b1, 4'd7, C_REX,       1'b0, 0};
      tab[3]  = '{OP_SW, 1'b0, 4'd8, C_RWB,       1'b1, 0};
      tab[4]  = '{OP_R,  1'b1, 4'd1, C_FETCH_RDY, 1'b0, 1};
      tab[5]  = '{OP_LW, 1'b1, 4'd2, C_DECODE,    1'b0, 1};
      tab[6]  = '{OP_LW, 1'b0, 4'd3, C_MEMADR,    1'b0, 1};
      tab[7]  = '{OP_SW, 1'b0, 4'd4, C_MEMRD,     1'b0, 1};
      tab[8]  = '{OP_SW, 1'b0, 4'd4, C_MEMRD,     1'b0, 1};
      tab[9]  = '{OP_SW, 1'b1, 4'd4, C_MEMRD,     1'b0, 1};
      tab[10] = '{OP_R,  1'b1, 4'd5, C_MEMWB,     1'b1, 1};
      tab[11] = '{OP_R,  1'b0, 4'd1, C_FETCH,     1'b0, 2};
      tab[12] = '{OP_R,  1'b1, 4'd1, C_FETCH_RDY, 1'b0, 2};
      tab[13] = '{OP_BEQ,1'b0, 4'd2, C_DECODE,    1'b0, 2};
      tab[14] = '{6'h3F, 1'b1, 4'd9, C_BEQ,       1'b1, 2};
      tab[15] = '{OP_R,  1'b0, 4'd1, C_FETCH,     1'b0, 3};

      do_reset("rst0");
      for (int i = 0; i < 16; i++) run_vec(tab[i], $sformatf("tab[%0d]", i));

      // SW with MemReady held low: TIMEOUT cycles in MEMWR, then HALT, no retire
      do_reset("rst_sw_to");
      push(r6(), 1'b1, 4'd1, C_FETCH_RDY, 1'b0);
      push(OP_SW, 1'b0, 4'd2, C_DECODE, 1'b0);
      push(OP_SW, 1'b1, 4'd3, C_MEMADR, 1'b0);
      for (int i = 0; i < TIMEOUT; i++) push(r6(), 1'b0, 4'd6, C_MEMWR, 1'b0);
      for (int i = 0; i < 3; i++) push(r6(), r1(), 4'd11, C_HALT, 1'b0);
      run_q("sw_timeout");

      // MemReady arriving on the TIMEOUT-th wait cycle still succeeds
      do_reset("rst_sw_edge");
      gen_instr(OP_SW, 0, TIMEOUT - 1);
      push(r6(), 1'b0, 4'd1, C_FETCH, 1'b0);
      run_q("sw_edge");

      // FETCH also times out
      do_reset("rst_fetch_to");
      for (int i = 0; i < TIMEOUT; i++) push(r6(), 1'b0, 4'd1, C_FETCH, 1'b0);
      push(r6(), r1(), 4'd11, C_HALT, 1'b0);
      run_q("fetch_timeout");

      // Opcode 000010
      do_reset("rst_jump");
      push(r6(), 1'b1, 4'd1, C_FETCH_RDY, 1'b0);
      push(OP_J, r1(), 4'd2, C_DECODE, 1'b0);
`ifdef MCU_JUMP_EN
      push(r6(), r1(), 4'd10, C_JUMP, 1'b1);
      push(r6(), 1'b0, 4'd1, C_FETCH, 1'b0);
`else
      push(r6(), r1(), 4'd11, C_HALT, 1'b0);
      push(r6(), r1(), 4'd11, C_HALT, 1'b0);
`endif
      run_q("jump");

      // Illegal opcode in DECODE halts
      do_reset("rst_illegal");
      push(r6(), 1'b1, 4'd1, C_FETCH_RDY, 1'b0);
      push(6'h3F, r1(), 4'd2, C_DECODE, 1'b0);
      push(r6(), r1(), 4'd11, C_HALT, 1'b0);
      run_q("illegal");

      // Reset while a load waits in MEMRD
      do_reset("rst_pre_mid");
      gen_instr(OP_R, 0, 0);
      push(r6(), 1'b1, 4'd1, C_FETCH_RDY, 1'b0);
      push(OP_LW, r1(), 4'd2, C_DECODE, 1'b0);
      push(OP_LW, r1(), 4'd3, C_MEMADR, 1'b0);
      push(r6(), 1'b0, 4'd4, C_MEMRD, 1'b0);
      run_q("pre_mid");
      do_reset("rst_in_memrd");
      push(r6(), 1'b0, 4'd1, C_FETCH, 1'b0);
      run_q("post_mid");

      // Random legal instruction stream; more than 2^CNT_W retires forces wrap
      ops[0] = OP_R;
      ops[1] = OP_LW;
      ops[2] = OP_SW;
      ops[3] = OP_BEQ;
      ops[4] = OP_J;
`ifdef MCU_JUMP_EN
      nops = 5;
`else
      nops = 4;
`endif
      do_reset("rst_rand");
      gen_instr(OP_LW, pick_wait(), TIMEOUT - 1);
      for (int n = 0; n < 40; n++) begin
         gen_instr(ops[$urandom_range(0, nops - 1)], pick_wait(), pick_wait());
      end
      push(r6(), 1'b0, 4'd1, C_FETCH, 1'b0);
      run_q("rand");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
